// File: rtl/ser_pkg.sv
// Shared definitions for the parametrised serial receiver/transmitter family:
// parity modes, receive FSM states, per-entry flag layout and the baud divisor.
package ser_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_e;

    // Error flags stored above the data field of every FIFO entry
    typedef struct packed {
        logic brk;
        logic ferr;
        logic perr;
    } rx_flags_t;

    // round(clk_hz / (baud * ovs)), never below 1
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        longint unsigned den;
        longint unsigned q;
        den = 64'(baud) * 64'(ovs);
        q   = (64'(clk_hz) + den / 64'd2) / den;
        return (q == 64'd0) ? 32'd1 : 32'(q);
    endfunction

endpackage

// File: rtl/ser_sync_fifo.sv
// Generic synchronous show-ahead FIFO: the head entry is always on pop_data.
// A push while full is accepted only when a pop happens in the same cycle.
module ser_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/ser_rx_fifo.sv
// Oversampled serial receiver with majority-vote bit detection, parity/framing/
// break reporting and a show-ahead receive FIFO drained through a valid/ready port.
module ser_rx_fifo
    import ser_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned BAUD       = 57600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          pixclk,
    input  logic                          rst_n,
    input  logic                          serialrx,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          rd_break,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic                          busy
);
    localparam int unsigned DIV     = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned S_W     = $clog2(OVERSAMPLE);
    localparam int unsigned ENTRY_W = DATA_BITS + 3;
    localparam logic [S_W-1:0] SMP_A = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] SMP_B = S_W'(OVERSAMPLE / 2);
    localparam logic [S_W-1:0] SMP_C = S_W'(OVERSAMPLE / 2 + 1);
    localparam logic [S_W-1:0] S_END = S_W'(OVERSAMPLE - 1);

    rx_state_e            state;
    logic                 rx_meta;
    logic                 rxs;
    logic [DIV_W-1:0]     tick_cnt;
    logic [S_W-1:0]       s_cnt;
    logic                 v0;
    logic                 v1;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 any_one;
    logic                 stop_idx;
    logic                 hi_seen;
    logic                 push_q;
    logic [ENTRY_W-1:0]   push_data_q;
    logic [ENTRY_W-1:0]   head;
    rx_flags_t            head_flags;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 tick_c;
    logic                 vote_c;
    logic                 mid_c;
    logic                 end_c;
    logic                 brk_c;
    logic                 pop_c;

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= serialrx;
            rxs     <= rx_meta;
        end
    end

    // Sample tick; restarted on the start edge so sampling is phase-aligned to it
    assign tick_c = (tick_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (((state == S_IDLE) && !rxs) || tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign vote_c = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
    assign mid_c  = tick_c && (s_cnt == SMP_C);
    assign end_c  = tick_c && (s_cnt == S_END);
    // Break needs every bit up to and including the first stop bit at 0
    assign brk_c  = !any_one && (stop_idx || !vote_c);

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            s_cnt       <= '0;
            v0          <= 1'b1;
            v1          <= 1'b1;
            bit_idx     <= '0;
            shreg       <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            any_one     <= 1'b0;
            stop_idx    <= 1'b0;
            hi_seen     <= 1'b0;
            busy        <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (tick_c) begin
                s_cnt <= (s_cnt == S_END) ? '0 : s_cnt + 1'b1;
                if (s_cnt == SMP_A) v0 <= rxs;
                if (s_cnt == SMP_B) v1 <= rxs;
            end
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state    <= S_START;
                        busy     <= 1'b1;
                        s_cnt    <= '0;
                        bit_idx  <= '0;
                        perr_q   <= 1'b0;
                        ferr_q   <= 1'b0;
                        any_one  <= 1'b0;
                        stop_idx <= 1'b0;
                    end
                end
                S_START: begin
                    if (mid_c && vote_c) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (end_c) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (mid_c) begin
                        shreg <= {vote_c, shreg[DATA_BITS-1:1]};
                        if (vote_c) any_one <= 1'b1;
                    end
                    if (end_c) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (mid_c) begin
                        perr_q <= (^{shreg, vote_c}) != (PARITY == PAR_ODD);
                        if (vote_c) any_one <= 1'b1;
                    end
                    if (end_c) state <= S_STOP;
                end
                S_STOP: begin
                    if (mid_c) begin
                        if (!vote_c) ferr_q <= 1'b1;
                        if (vote_c && !stop_idx) any_one <= 1'b1;
                        if (stop_idx == 1'(STOP_BITS - 1)) begin
                            push_q      <= 1'b1;
                            push_data_q <= {brk_c, ferr_q | !vote_c, perr_q, shreg};
                            if (vote_c) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state   <= S_WAIT_HIGH;
                                hi_seen <= 1'b0;
                            end
                        end
                    end
                    if (end_c) stop_idx <= 1'b1;
                end
                S_WAIT_HIGH: begin
                    // Leave only after the line has stayed high across a whole tick
                    if (!rxs) begin
                        hi_seen <= 1'b0;
                    end else if (tick_c) begin
                        if (hi_seen) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            hi_seen <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_valid = !fifo_empty;
    assign pop_c    = rd_valid && rd_ready;

    // Sticky overrun; a drop in the same cycle as ovr_clr wins
    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (push_q && fifo_full && !pop_c) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    ser_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (pixclk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (push_data_q),
        .full      (fifo_full),
        .pop       (rd_ready),
        .pop_data  (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_flags = head[ENTRY_W-1:DATA_BITS];
    assign rd_data    = head[DATA_BITS-1:0];
    assign rd_perr    = head_flags.perr;
    assign rd_ferr    = head_flags.ferr;
    assign rd_break   = head_flags.brk;

endmodule
